// File: rtl/timer.sv
// Free-running elapsed-tick timer: a prescaler divides enabled clock cycles,
// and each prescaler rollover advances a 27-bit wrapping time register.
module timer #(
  parameter int unsigned PRESCALE  = 1,
  parameter logic [26:0] MAX_COUNT = 27'h7FF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        toggle,
  output logic [26:0] out_time
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;
  logic          tick;

  // With PRESCALE=1 the counter is pinned at 0, so every enabled edge ticks.
  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt  <= '0;
      out_time <= '0;
    end else if (toggle) begin
      if (tick) begin
        pre_cnt  <= '0;
        out_time <= (out_time == MAX_COUNT) ? '0 : out_time + 27'd1;
      end else begin
        pre_cnt <= pre_cnt + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_timer.sv
// Bench for timer: five parameterisations share one reset/toggle stream and are
// checked every cycle against a count of enabled edges since the last reset.
module tb_timer;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic        toggle = 1'b1;
  logic [26:0] out_a, out_b, out_c, out_d, out_e;

  int checks   = 0;
  int failures = 0;

  // Enabled edges since the last reset; every instance's time follows from it.
  longint n = 0;

  always #5 clk = ~clk;

  timer u_a (.clk(clk), .reset(reset), .toggle(toggle), .out_time(out_a));
  timer #(.PRESCALE(4)) u_b (.clk(clk), .reset(reset), .toggle(toggle), .out_time(out_b));
  timer #(.PRESCALE(1), .MAX_COUNT(27'd9)) u_c (.clk(clk), .reset(reset), .toggle(toggle), .out_time(out_c));
  timer #(.PRESCALE(3), .MAX_COUNT(27'd5)) u_d (.clk(clk), .reset(reset), .toggle(toggle), .out_time(out_d));
  timer #(.PRESCALE(5), .MAX_COUNT(27'd1000)) u_e (.clk(clk), .reset(reset), .toggle(toggle), .out_time(out_e));

  always @(posedge clk or posedge reset) begin
    if (reset)       n <= 0;
    else if (toggle) n <= n + 1;
  end

  function automatic logic [63:0] expv(longint cnt, longint p, longint m);
    return 64'((cnt / p) % (m + 1));
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("model_a", {37'd0, out_a}, expv(n, 1, 64'h7FF_FFFF));
    check("model_b", {37'd0, out_b}, expv(n, 4, 64'h7FF_FFFF));
    check("model_c", {37'd0, out_c}, expv(n, 1, 9));
    check("model_d", {37'd0, out_d}, expv(n, 3, 5));
    check("model_e", {37'd0, out_e}, expv(n, 5, 1000));
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Pulse reset between edges and confirm everything clears before the next edge.
  task automatic async_pulse();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_a", {37'd0, out_a}, 64'd0);
    check("async_b", {37'd0, out_b}, 64'd0);
    check("async_d", {37'd0, out_d}, 64'd0);
    #1 reset = 1'b0;
  endtask

  initial begin
    // Reset dominance with toggle high.
    toggle = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      check("rst_hold_a", {37'd0, out_a}, 64'd0);
      check("rst_hold_b", {37'd0, out_b}, 64'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Basic count, prescale and wrap, counted from reset release.
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (k == 1)  check("first_edge_a", {37'd0, out_a}, 64'd1);
      if (k <= 3)  check("pre4_early_b", {37'd0, out_b}, 64'd0);
      if (k == 4)  check("pre4_tick_b", {37'd0, out_b}, 64'd1);
      if (k == 40) check("pre4_40_b", {37'd0, out_b}, 64'd10);
      if (k == 8)  check("wrap8_c", {37'd0, out_c}, 64'd8);
      if (k == 9)  check("wrap9_c", {37'd0, out_c}, 64'd9);
      if (k == 10) check("wrap0_c", {37'd0, out_c}, 64'd0);
      if (k == 11) check("wrap1_c", {37'd0, out_c}, 64'd1);
      if (k == 100) check("count100_a", {37'd0, out_a}, 64'd100);
    end

    // Pause/resume keeps the partial prescale count.
    do_reset();
    toggle = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("pause_pre_b", {37'd0, out_b}, 64'd1);
    @(negedge clk);
    toggle = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("pause_hold_b", {37'd0, out_b}, 64'd1);
    @(negedge clk);
    toggle = 1'b1;
    @(posedge clk);
    #1 check("resume1_b", {37'd0, out_b}, 64'd1);
    @(posedge clk);
    #1 check("resume2_b", {37'd0, out_b}, 64'd2);

    // Async reset while out_time=37, then restart at 1.
    do_reset();
    toggle = 1'b1;
    repeat (37) @(posedge clk);
    #1 check("at37_a", {37'd0, out_a}, 64'd37);
    async_pulse();
    @(posedge clk);
    #1 check("restart_a", {37'd0, out_a}, 64'd1);

    // Randomised toggle with occasional sync and async resets.
    repeat (4000) begin
      @(negedge clk);
      toggle = ($urandom_range(3) != 0);
      if ($urandom_range(299) == 0) async_pulse();
      else if ($urandom_range(299) == 0) do_reset();
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 Parameter PRESCALE, default 1: number of enabled clock cycles per out_time increment; legal range 1..2^24.
REQ-002 Parameter MAX_COUNT, default 27'h7FF_FFFF: terminal value of out_time before wrap; must be at most 2^27-1.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: reset, asynchronous and active-high.
REQ-005 Port toggle, input, 1: run enable, level-sensitive; 1 = count, 0 = pause/hold.
REQ-006 Port out_time, output, 27: elapsed tick count, unsigned binary, driven directly from a register.

Function
REQ-007 The block SHALL contain a prescale counter (width ceil(log2(PRESCALE)), minimum 1 bit) and a 27-bit time register driving out_time.
REQ-008 On a rising clk edge with reset=0 and toggle=1, the prescale counter SHALL increment by 1.
REQ-009 When the prescale counter equals PRESCALE-1 on an enabled edge, it SHALL return to 0 on that edge, and out_time SHALL advance by 1 on the same edge.
REQ-010 With PRESCALE=1, out_time SHALL advance on every rising edge where toggle=1.
REQ-011 Advance rule: if out_time equals MAX_COUNT, the next value SHALL be 0 (wrap); otherwise the next value SHALL be out_time+1. No saturation and no overflow flag.
REQ-012 On a rising edge with toggle=0, the prescale counter and out_time SHALL both hold.
REQ-013 A partial prescale count SHALL be kept across a pause, so resuming continues the same tick.
REQ-014 toggle SHALL be sampled synchronously on the rising clk edge with no internal synchronizer, giving zero cycles of added latency.
REQ-015 The driving logic SHALL meet setup and hold on toggle relative to clk.
REQ-016 out_time SHALL change only on a rising clk edge or on reset assertion, never combinationally from toggle.
REQ-017 The block SHALL have no other outputs or side effects.

Reset
REQ-018 While reset=1, out_time SHALL be 0 and the prescale counter SHALL be 0, independent of clk and toggle.
REQ-019 Reset assertion SHALL clear all state immediately and asynchronously, including in the middle of a prescale period or at MAX_COUNT.
REQ-020 The first rising edge after reset falls SHALL be treated as an ordinary edge: with toggle=1 and PRESCALE=1, out_time becomes 1 on that edge.
REQ-021 Reset SHALL take priority over toggle and over the wrap logic.
REQ-022 Repeated reset pulses during a run SHALL restart counting from 0 each time.

Verification
REQ-023 Basic count, PRESCALE=1: reset=1, then release with toggle=1 -> out_time reads 1, 2, 3, ... on successive edges; after 100 edges it reads 100.
REQ-024 Prescale, PRESCALE=4, toggle=1 from reset release -> out_time is 0 after edges 1-3 and 1 after edge 4; after 40 edges it reads 10.
REQ-025 Pause/resume, PRESCALE=4: run 6 edges (out_time=1, prescale=2), toggle=0 for 10 edges (values hold), toggle=1 again -> out_time becomes 2 on the 2nd enabled edge.
REQ-026 Wrap, MAX_COUNT=9, PRESCALE=1 -> out_time sequence ...8, 9, 0, 1; with the default MAX_COUNT, 27'h7FF_FFFF wraps to 0.
REQ-027 Async reset mid-run: reset pulses high between clk edges while out_time=37 -> out_time reads 0 before the next edge; after release the count restarts at 1.
REQ-028 Reset dominance: hold reset=1 with toggle=1 for 20 edges -> out_time stays 0 throughout.
